// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over req/gnt + rvalid, holds the word until acked.
// Optional misaligned-target trap enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_unit #(
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           INSTR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   pc_src,
   input  logic [ADDR_WIDTH-1:0]  imm_ext,
   input  logic                   instr_ack,
   output logic                   imem_req,
   output logic [ADDR_WIDTH-1:0]  imem_addr,
   input  logic                   imem_gnt,
   input  logic                   imem_rvalid,
   input  logic [INSTR_WIDTH-1:0] imem_rdata,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic                   instr_valid,
   output logic [ADDR_WIDTH-1:0]  pc,
   output logic [ADDR_WIDTH-1:0]  pc_plus4,
   output logic                   fetch_err
);

   localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(32'h0000_0013);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
`ifdef FETCH_MISALIGN_CHECK_EN
      S_VALID,
      S_ERR
`else
      S_VALID
`endif
   } state_e;

   state_e                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic [ADDR_WIDTH-1:0]  target;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= NOP;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   assign pc_plus4 = pc_q + ADDR_WIDTH'(4);
   assign target   = pc_src ? (pc_q + imm_ext) : pc_plus4;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      unique case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            // a same-cycle rvalid is a stale response and is dropped
            if (imem_gnt) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               instr_d = imem_rdata;
               state_d = S_VALID;
            end
         end
         S_VALID: begin
            if (instr_ack) begin
`ifdef FETCH_MISALIGN_CHECK_EN
               pc_d    = target;
               state_d = (target[1:0] != 2'b00) ? S_ERR : S_REQ;
`else
               pc_d    = target & ~ADDR_WIDTH'(3);
               state_d = S_REQ;
`endif
            end
         end
`ifdef FETCH_MISALIGN_CHECK_EN
         S_ERR: state_d = S_ERR;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   assign imem_req    = (state_q == S_REQ);
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign instr_valid = (state_q == S_VALID);
`ifdef FETCH_MISALIGN_CHECK_EN
   assign fetch_err   = (state_q == S_ERR);
`else
   assign fetch_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded random bench for fetch_unit with a PC-sequence reference model and memory model.
module tb_fetch_unit;
   localparam int unsigned     AW     = 32;
   localparam int unsigned     IW     = 32;
   localparam logic [AW-1:0]   RST_PC = 32'h0000_0000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          pc_src;
   logic [AW-1:0] imm_ext;
   logic          instr_ack;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_gnt;
   logic          imem_rvalid;
   logic [IW-1:0] imem_rdata;
   logic [IW-1:0] instr;
   logic          instr_valid;
   logic [AW-1:0] pc;
   logic [AW-1:0] pc_plus4;
   logic          fetch_err;

   fetch_unit #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_PC(RST_PC)) dut (
      .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .imm_ext(imm_ext), .instr_ack(instr_ack),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr),
      .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [IW-1:0] instr;
   } out_t;

   int          checks = 0;
   int          errors = 0;
   logic [AW-1:0] exp_req_q[$];
   out_t        exp_out_q[$];
   bit          scr_src[$];
   logic [AW-1:0] scr_imm[$];

   bit            mon_en = 1'b0;
   bit            pending = 1'b0;
   int            dly = 0;
   logic [AW-1:0] resp_addr = '0;
   bit            resp_now = 1'b0;
   logic [AW-1:0] model_pc = '0;
   int            n_acks = 0;

   logic          prev_req = 1'b0, prev_gnt = 1'b0, prev_valid = 1'b0, prev_ack = 1'b0, prev_resp = 1'b0;
   logic [AW-1:0] prev_addr = '0, prev_pc = '0;
   logic [IW-1:0] prev_instr = '0;
   out_t          mon_o;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory contents as a fixed function of address
   function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Reference next-PC rule: modulo-2^32 add, word-aligned unless the trap build is used
   function automatic logic [AW-1:0] next_pc(input logic [AW-1:0] cur, input bit src,
                                              input logic [AW-1:0] imm);
      logic [AW-1:0] t;
      t = src ? cur + imm : cur + 32'd4;
`ifndef FETCH_MISALIGN_CHECK_EN
      t[1:0] = 2'b00;
`endif
      return t;
   endfunction

   function automatic logic [AW-1:0] rand_imm();
      int unsigned   sel;
      logic [AW-1:0] r;
      sel = $urandom_range(0, 9);
      r   = $urandom;
      if (sel < 6) return 32'($urandom_range(0, 64) * 4) - 32'd128;
      if (sel < 8) return r & 32'hFFFF_FFFC;
`ifndef FETCH_MISALIGN_CHECK_EN
      if (sel == 8) return r;
`endif
      return 32'hFFFF_FFFC;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_random(input int unsigned ncyc);
      for (int unsigned c = 0; c < ncyc; c++) begin
         tick();
         resp_now = 1'b0;
         if (pending) begin
            if (dly == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = mem_word(resp_addr);
               pending     = 1'b0;
               resp_now    = 1'b1;
            end else begin
               dly--;
               imem_rvalid = 1'b0;
               imem_rdata  = $urandom;
            end
         end else begin
            imem_rvalid = ($urandom_range(0, 9) == 0);
            imem_rdata  = $urandom;
         end
         imem_gnt = ($urandom_range(0, 9) < 6);
         if (imem_req && imem_gnt) begin
            pending   = 1'b1;
            dly       = $urandom_range(0, 2);
            resp_addr = imem_addr;
            exp_out_q.push_back('{pc: model_pc, instr: mem_word(model_pc)});
         end
         if (instr_valid && scr_src.size() > 0) begin
            instr_ack = 1'b1;
            pc_src    = scr_src.pop_front();
            imm_ext   = scr_imm.pop_front();
         end else begin
            instr_ack = ($urandom_range(0, 2) == 0);
            pc_src    = $urandom_range(0, 1);
            imm_ext   = rand_imm();
         end
         if (instr_valid && instr_ack) begin
            model_pc = next_pc(model_pc, pc_src, imm_ext);
            exp_req_q.push_back(model_pc);
            n_acks++;
         end
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (imem_req && imem_gnt) begin
            if (exp_req_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL req_unexpected: got addr %h expected no request", imem_addr);
            end else chk("req_addr", imem_addr, exp_req_q.pop_front());
         end
         if (instr_valid && instr_ack) begin
            if (exp_out_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL instr_unexpected: got %h expected no instruction", instr);
            end else begin
               mon_o = exp_out_q.pop_front();
               chk("instr", instr, mon_o.instr);
               chk("pc", pc, mon_o.pc);
               chk("pc_plus4", pc_plus4, mon_o.pc + 32'd4);
            end
         end
         if (prev_req && !prev_gnt) begin
            chk("req_hold", imem_req, 1);
            chk("addr_hold", imem_addr, prev_addr);
         end
         if (prev_valid && !prev_ack) begin
            chk("stall_valid", instr_valid, 1);
            chk("stall_instr", instr, prev_instr);
            chk("stall_pc", pc, prev_pc);
         end
         chk("valid_latency", instr_valid && !prev_valid, prev_resp);
         chk("req_during_valid", imem_req && instr_valid, 0);
         chk("fetch_err_idle", fetch_err, 0);
         prev_req   <= imem_req;
         prev_gnt   <= imem_gnt;
         prev_addr  <= imem_addr;
         prev_valid <= instr_valid;
         prev_ack   <= instr_ack;
         prev_instr <= instr;
         prev_pc    <= pc;
         prev_resp  <= resp_now;
      end
   end

   initial begin
      rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      instr_ack = 1'b0; pc_src = 1'b0; imm_ext = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req", imem_req, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_instr", instr, 32'h0000_0013);
      chk("rst_pc", pc, RST_PC);
      chk("rst_addr", imem_addr, RST_PC);
      chk("rst_pc_plus4", pc_plus4, RST_PC + 32'd4);
      chk("rst_err", fetch_err, 0);

      // Directed PC walk first: wrap to FFFF_FFFC, wrap back to 0, then 0x10 -> 0x14 -> 0x0C
      model_pc = RST_PC;
      exp_req_q.push_back(RST_PC);
      scr_src = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      scr_imm = {32'hFFFF_FFFC, 32'h0, 32'h10, 32'h0, 32'hFFFF_FFF8};
      tick();
      rst_n  = 1'b1;
      mon_en = 1'b1;
      run_random(3000);
      mon_en = 1'b0;
      chk("progress_acks", n_acks >= 20, 1);

      // Reset while waiting for a response; the late rvalid must be dropped
      tick();
      imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_ack = 1'b0; pc_src = 1'b0; imm_ext = '0;
      pending = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("rw_req", imem_req, 1);
      chk("rw_addr", imem_addr, RST_PC);
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      chk("rw_wait_req", imem_req, 0);
      rst_n = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      #1;
      chk("rw_async_valid", instr_valid, 0);
      chk("rw_async_instr", instr, 32'h0000_0013);
      chk("rw_async_pc", pc, RST_PC);
      tick();
      chk("rw_hold_instr", instr, 32'h0000_0013);
      chk("rw_hold_valid", instr_valid, 0);
      imem_rvalid = 1'b0; rst_n = 1'b1;
      tick();
      chk("rw_restart_req", imem_req, 1);
      chk("rw_restart_addr", imem_addr, RST_PC);
      chk("rw_restart_valid", instr_valid, 0);
      chk("rw_restart_instr", instr, 32'h0000_0013);

      // Misaligned branch target (+2)
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = mem_word(RST_PC);
      tick();
      imem_rvalid = 1'b0;
      chk("mis_valid", instr_valid, 1);
      chk("mis_instr", instr, mem_word(RST_PC));
      instr_ack = 1'b1; pc_src = 1'b1; imm_ext = 32'h0000_0002;
      tick();
      instr_ack = 1'b0; pc_src = 1'b0; imm_ext = '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      imem_gnt = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("err_flag", fetch_err, 1);
         chk("err_req", imem_req, 0);
         chk("err_valid", instr_valid, 0);
         chk("err_pc", pc, RST_PC + 32'd2);
         tick();
      end
      imem_gnt = 1'b0;
`else
      chk("mis_err", fetch_err, 0);
      chk("mis_req", imem_req, 1);
      chk("mis_addr", imem_addr, RST_PC);
      chk("mis_pc", pc, RST_PC);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
